genius_core: RTL and testbench

Parametrised successor to the fixed three-button Genius (Simon) game core. It generates a pseudo-random colour sequence, plays it back on one-hot LEDs, checks the player's button presses against it, and lengthens the sequence by one each round until the player wins at `MAX_LEN` or makes an error. It sits between the debounced button/switch inputs and the seven-segment/LED display drivers; the score/round outputs feed the display decoders.

---
 rtl/genius_core.sv | 218 +++++++++++++++++++++
 tb/tb_genius_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/genius_core.sv
// genius_core: Simon-style colour memory game with LFSR sequence and LED replay.
// Optional input-idle timeout is enabled by defining GENIUS_TIMEOUT_EN.
module genius_core #(
    parameter int          NUM_BTN       = 4,
    parameter int          MAX_LEN       = 32,
    parameter int          SHOW_TICKS    = 25_000_000,
    parameter int          GAP_TICKS     = 12_500_000,
    parameter int          TIMEOUT_TICKS = 250_000_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [1:0]         speed,
    output logic [NUM_BTN-1:0] leds,
    output logic [7:0]         round,
    output logic [7:0]         score,
    output logic [2:0]         state,
    output logic               win,
    output logic               lose
);

    localparam int SW = $clog2(NUM_BTN);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [NUM_BTN-1:0] ONE = NUM_BTN'(1);
    localparam logic [15:0] NB = 16'(NUM_BTN);
    localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    state_t cur;
    state_t nxt;

    logic [15:0]        lfsr;
    logic               start_q;
    logic [NUM_BTN-1:0] btn_q;
    logic [SW-1:0]      mem [MAX_LEN];
    logic [7:0]         idx;
    logic [31:0]        timer;
    logic [1:0]         spd;

    logic               start_edge;
    logic [NUM_BTN-1:0] btn_edge;
    logic [SW-1:0]      symbol;
    logic [SW-1:0]      cur_sym;
    logic [NUM_BTN-1:0] cur_oh;
    logic [7:0]         idx_inc;
    logic               more;
    logic               last;
    logic               press_ok;
    logic               press_bad;
    logic               timer_done;
    logic               timeout;
    logic [31:0]        show_sh;
    logic [31:0]        gap_sh;
    logic [31:0]        show_len;
    logic [31:0]        gap_len;

    assign start_edge = start & ~start_q;
    assign btn_edge   = btn & ~btn_q;
    assign symbol     = SW'(lfsr % NB);
    assign cur_sym    = mem[idx[AW-1:0]];
    assign cur_oh     = ONE << cur_sym;
    assign idx_inc    = idx + 8'd1;
    assign more       = idx_inc < round;
    assign last       = idx_inc == round;
    assign press_ok   = btn_edge == cur_oh;
    assign press_bad  = (|btn_edge) & ~press_ok;
    assign timer_done = timer == 32'd0;

    // A shifted phase length of zero would never expire, so clamp to one cycle.
    assign show_sh  = 32'(SHOW_TICKS) >> spd;
    assign gap_sh   = 32'(GAP_TICKS) >> spd;
    assign show_len = (show_sh == 32'd0) ? 32'd1 : show_sh;
    assign gap_len  = (gap_sh == 32'd0) ? 32'd1 : gap_sh;

    // Free-running Galois LFSR (taps 16,14,13,11) and input edge history.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr    <= LFSR_SEED;
            start_q <= 1'b1;
            btn_q   <= '1;
        end else begin
            lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            start_q <= start;
            btn_q   <= btn;
        end
    end

`ifdef GENIUS_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // Idle counter runs only while waiting for a press in INPUT.
    always_ff @(posedge clock) begin
        if (reset || cur != S_INPUT || press_ok) begin
            idle_cnt <= 32'd0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign timeout = (cur == S_INPUT) && (idle_cnt == 32'(TIMEOUT_TICKS));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start_edge) nxt = S_ADD;
            end
            S_ADD: nxt = S_SHOW_ON;
            S_SHOW_ON: begin
                if (timer_done) nxt = S_SHOW_OFF;
            end
            S_SHOW_OFF: begin
                if (timer_done) nxt = more ? S_SHOW_ON : S_INPUT;
            end
            S_INPUT: begin
                if (press_bad || (timeout && !press_ok)) begin
                    nxt = S_LOSE;
                end else if (press_ok && last) begin
                    nxt = (round == LEN_MAX) ? S_WIN : S_ADD;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Round, score, replay index and phase timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            round <= 8'd0;
            score <= 8'd0;
            idx   <= 8'd0;
            timer <= 32'd0;
            spd   <= 2'd0;
        end else begin
            unique case (cur)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start_edge) begin
                        round <= 8'd0;
                        score <= 8'd0;
                        spd   <= speed;
                    end
                end
                S_ADD: begin
                    round <= round + 8'd1;
                    idx   <= 8'd0;
                    timer <= show_len - 32'd1;
                end
                S_SHOW_ON: begin
                    timer <= timer_done ? gap_len - 32'd1 : timer - 32'd1;
                end
                S_SHOW_OFF: begin
                    if (!timer_done) begin
                        timer <= timer - 32'd1;
                    end else if (more) begin
                        idx   <= idx_inc;
                        timer <= show_len - 32'd1;
                    end else begin
                        idx <= 8'd0;
                    end
                end
                S_INPUT: begin
                    if (press_ok) begin
                        if (last) score <= round;
                        else      idx   <= idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequence memory: append one symbol per round, no reset needed.
    always_ff @(posedge clock) begin
        if (cur == S_ADD) begin
            mem[round[AW-1:0]] <= symbol;
        end
    end

    // Output decode from registered state.
    always_comb begin
        leds = '0;
        unique case (cur)
            S_SHOW_ON: leds = cur_oh;
            S_INPUT:   leds = btn_q;
            S_WIN:     leds = '1;
            default:   leds = '0;
        endcase
    end

    assign state = cur;
    assign win   = cur == S_WIN;
    assign lose  = cur == S_LOSE;

endmodule

// File: tb/tb_genius_core.sv
// tb_genius_core: table-driven check of genius_core with a reference LFSR.
// Build with or without GENIUS_TIMEOUT_EN; the idle-phase check adapts.
module tb_genius_core;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] btn   = 3'b000;
    logic [1:0] speed = 2'd0;
    logic [2:0] leds;
    logic [7:0] round;
    logic [7:0] score;
    logic [2:0] state;
    logic       win;
    logic       lose;

    genius_core #(
        .NUM_BTN(3),
        .MAX_LEN(2),
        .SHOW_TICKS(4),
        .GAP_TICKS(2),
        .TIMEOUT_TICKS(20),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .btn(btn),
        .speed(speed),
        .leds(leds),
        .round(round),
        .score(score),
        .state(state),
        .win(win),
        .lose(lose)
    );

    always #5 clock = ~clock;

    // Reference LFSR: x^16+x^14+x^13+x^11, right-shifting Galois form.
    logic [15:0] m_lfsr;
    always @(posedge clock) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
    end

    // bc: 0 none, 1 correct sym[bk], 2 wrong, 3 raw braw, 4 correct+other
    // lc: 0 off, 1 onehot(sym[lk]), 2 all on
    typedef struct {
        logic       rst;
        logic       st;
        int         bc;
        int         bk;
        logic [2:0] braw;
        logic [2:0] es;
        int         er;
        int         esc;
        int         lc;
        int         lk;
    } vec_t;

    vec_t tab[$];
    int   sym[2];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t v(input logic r, input logic s,
                               input int bc, input int bk,
                               input logic [2:0] braw,
                               input logic [2:0] es, input int er,
                               input int esc, input int lc, input int lk);
        vec_t t;
        t.rst = r;  t.st = s;  t.bc = bc;  t.bk = bk;  t.braw = braw;
        t.es = es;  t.er = er; t.esc = esc; t.lc = lc; t.lk = lk;
        return t;
    endfunction

    function automatic logic [2:0] oh(input int s);
        logic [2:0] one;
        one = 3'b001;
        return one << s;
    endfunction

    task automatic chk(input string name, input int step,
                       input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h",
                     name, step, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_n(input int n, input vec_t t);
        for (int i = 0; i < n; i++) tab.push_back(t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] el;
        int         n;

        // reset with start held high, then a clean start edge
        push_n(2, v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        push_n(1, v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_n(1, v(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        // round 1 show: press during SHOW_ON ignored
        push_n(1, v(0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        push_n(1, v(0, 0, 3, 0, 3'b111, 2, 1, 0, 1, 0));
        push_n(2, v(0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        push_n(2, v(0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        push_n(1, v(0, 0, 1, 0, 0, 1, 1, 1, 0, 0));
        // round 2 replay of two symbols
        push_n(4, v(0, 0, 0, 0, 0, 2, 2, 1, 1, 0));
        push_n(2, v(0, 0, 0, 0, 0, 3, 2, 1, 0, 0));
        push_n(4, v(0, 0, 0, 0, 0, 2, 2, 1, 1, 1));
        push_n(2, v(0, 0, 0, 0, 0, 3, 2, 1, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 4, 2, 1, 0, 0));
        push_n(1, v(0, 0, 1, 0, 0, 4, 2, 1, 1, 0));
        push_n(1, v(0, 0, 0, 0, 0, 4, 2, 1, 0, 0));
        push_n(1, v(0, 0, 1, 1, 0, 5, 2, 2, 2, 0));
        push_n(1, v(0, 0, 0, 0, 0, 5, 2, 2, 2, 0));
        // new game from WIN, then a wrong press
        push_n(1, v(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        push_n(4, v(0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        push_n(2, v(0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        push_n(1, v(0, 0, 2, 0, 0, 6, 1, 0, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 6, 1, 0, 0, 0));
        push_n(1, v(0, 0, 3, 0, 3'b111, 6, 1, 0, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 6, 1, 0, 0, 0));
        // new game from LOSE, then a double press
        push_n(1, v(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        push_n(4, v(0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        push_n(2, v(0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
        push_n(1, v(0, 0, 4, 0, 0, 6, 1, 0, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 6, 1, 0, 0, 0));
        // reset in the middle of a show
        push_n(1, v(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        push_n(2, v(0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        push_n(1, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // fresh game after reset; ends waiting in INPUT
        push_n(1, v(0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        push_n(4, v(0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        push_n(2, v(0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        push_n(1, v(0, 0, 0, 0, 0, 4, 1, 0, 0, 0));

        sym[0] = 0;
        sym[1] = 0;

        for (int i = 0; i < tab.size(); i++) begin
            vec_t t;
            t = tab[i];
            reset = t.rst;
            start = t.st;
            case (t.bc)
                1: btn = oh(sym[t.bk]);
                2: btn = oh((sym[t.bk] + 1) % 3);
                3: btn = t.braw;
                4: btn = oh(sym[t.bk]) | oh((sym[t.bk] + 1) % 3);
                default: btn = 3'b000;
            endcase
            tick();
            if (t.es == 3'd1) sym[t.er] = int'(m_lfsr % 16'd3);
            case (t.lc)
                1: el = oh(sym[t.lk]);
                2: el = 3'b111;
                default: el = 3'b000;
            endcase
            chk("state", i, 8'(state), 8'(t.es));
            chk("round", i, round, 8'(t.er));
            chk("score", i, score, 8'(t.esc));
            chk("leds", i, 8'(leds), 8'(el));
            chk("win", i, 8'(win), 8'(t.es == 3'd5));
            chk("lose", i, 8'(lose), 8'(t.es == 3'd6));
        end

        btn = 3'b000;
        start = 1'b0;
`ifdef GENIUS_TIMEOUT_EN
        // idle in INPUT until the timeout fires
        n = 0;
        while (state != 3'd6 && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_state", 0, 8'(state), 8'd6);
        chk("timeout_cycles", 0, 8'(n), 8'd21);
        chk("timeout_lose", 0, 8'(lose), 8'd1);
`else
        // no timeout: INPUT waits, then a late correct press still counts
        n = 0;
        repeat (100) begin
            tick();
            n++;
        end
        chk("idle_state", n, 8'(state), 8'd4);
        btn = oh(sym[0]);
        tick();
        chk("late_press_state", 0, 8'(state), 8'd1);
        chk("late_press_score", 0, score, 8'd1);
        btn = 3'b000;
        tick();
        chk("late_next_state", 0, 8'(state), 8'd2);
        chk("late_next_round", 0, round, 8'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
